alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/ops.svh | 15 +
 rtl/alu_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ops.svh
// Opcode encodings for alu_pipe.
`ifndef ALU_OPS_SVH
`define ALU_OPS_SVH
localparam logic [3:0] OP_ADD = 4'b0000;
localparam logic [3:0] OP_SUB = 4'b0001;
localparam logic [3:0] OP_AND = 4'b0010;
localparam logic [3:0] OP_OR  = 4'b0011;
localparam logic [3:0] OP_XOR = 4'b0100;
localparam logic [3:0] OP_NOT = 4'b0101;
localparam logic [3:0] OP_LLS = 4'b0110;
localparam logic [3:0] OP_LRS = 4'b0111;
localparam logic [3:0] OP_ARS = 4'b1000;
localparam logic [3:0] OP_ADC = 4'b1001;
localparam logic [3:0] OP_MUL = 4'b1010;
`endif

// File: rtl/alu_pipe.sv
// Registered ALU: single-cycle ops land one cycle after acceptance, MUL iterates shift-add
// for WIDTH cycles; the result register holds under backpressure and blocks new requests.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

`include "ops.svh"

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam int M = WIDTH - 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               vld_q, vld_d;
    logic               c_q, c_d;

    logic               accept;
    logic [WIDTH-1:0]   res_y;
    logic               res_cout, res_ovf, res_err;
    logic [WIDTH:0]     ext;
    logic [31:0]        amt;
    logic               carry;
    logic [2*WIDTH-1:0] pp, prod;
    logic               load;
    logic [WIDTH-1:0]   ld_y;
    logic               ld_cout, ld_ovf, ld_err;

    assign in_ready = !rst && (state_q == S_IDLE) && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; the extra ext bit carries cout / the last bit shifted out.
    always_comb begin
        res_y    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        res_err  = 1'b0;
        ext      = '0;
        amt      = 32'(b);
        carry    = (op == OP_ADC) ? c_q : cin;
        case (op)
            OP_ADD, OP_ADC: begin
                ext      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
                res_y    = ext[WIDTH-1:0];
                res_cout = ext[WIDTH];
                res_ovf  = (a[M] == b[M]) && (res_y[M] != a[M]);
            end
            OP_SUB: begin
                ext      = {1'b0, a} - {1'b0, b};
                res_y    = ext[WIDTH-1:0];
                res_cout = ~ext[WIDTH];
                res_ovf  = (a[M] != b[M]) && (res_y[M] != a[M]);
            end
            OP_AND: res_y = a & b;
            OP_OR:  res_y = a | b;
            OP_XOR: res_y = a ^ b;
            OP_NOT: res_y = ~a;
            OP_LLS: begin
                if (amt < 32'(WIDTH)) begin
                    ext      = {1'b0, a} << amt;
                    res_y    = ext[WIDTH-1:0];
                    res_cout = ext[WIDTH];
                end
            end
            OP_LRS: begin
                if (amt < 32'(WIDTH)) begin
                    ext      = {a, 1'b0} >> amt;
                    res_y    = ext[WIDTH:1];
                    res_cout = ext[0];
                end
            end
            OP_ARS: begin
                if (amt < 32'(WIDTH)) begin
                    ext      = $unsigned($signed({a, 1'b0}) >>> amt);
                    res_y    = ext[WIDTH:1];
                    res_cout = ext[0];
                end else begin
                    res_y    = {WIDTH{a[M]}};
                    res_cout = a[M];
                end
            end
            OP_MUL: ;
            default: res_err = 1'b1;
        endcase
    end

    assign pp   = mplier_q[0] ? mcand_q : '0;
    assign prod = acc_q + pp;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        load     = 1'b0;
        ld_y     = res_y;
        ld_cout  = res_cout;
        ld_ovf   = res_ovf;
        ld_err   = res_err;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    load    = 1'b1;
                    ld_y    = prod[WIDTH-1:0];
                    ld_cout = |prod[2*WIDTH-1:WIDTH];
                    ld_ovf  = 1'b0;
                    ld_err  = 1'b0;
                end
            end
        endcase
    end

    // Result register reloads only on a new result, so it holds while the consumer stalls.
    always_comb begin
        y_d    = y_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        err_d  = err_q;
        c_d    = c_q;
        vld_d  = vld_q && !out_ready;
        if (load) begin
            vld_d  = 1'b1;
            y_d    = ld_y;
            cout_d = ld_cout;
            ovf_d  = ld_ovf;
            neg_d  = ld_y[M];
            zero_d = (ld_y == '0);
            err_d  = ld_err;
            if (!ld_err) begin
                c_d = ld_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            y_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            y_q      <= y_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            c_q      <= c_d;
        end
    end

    assign y         = y_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=4: directed scenarios plus randomized traffic
// compared against an arithmetic reference model with a cycle-level handshake model.
module tb_alu_pipe;
    localparam int W = 4;

    localparam logic [3:0] T_ADD = 4'd0,  T_SUB = 4'd1,  T_AND = 4'd2, T_OR  = 4'd3;
    localparam logic [3:0] T_XOR = 4'd4,  T_NOT = 4'd5,  T_LLS = 4'd6, T_LRS = 4'd7;
    localparam logic [3:0] T_ARS = 4'd8,  T_ADC = 4'd9,  T_MUL = 4'd10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] y;
    logic         cout, overflow, negative, zero, err;
    logic         out_valid;
    logic         out_ready = 1'b1;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .cout(cout), .overflow(overflow), .negative(negative), .zero(zero),
        .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned y;
        bit cout, ovf, neg, zero, err;
    } res_t;

    // Reference ALU from plain integer arithmetic.
    function automatic res_t ref_alu(input int unsigned o, input int unsigned ai,
                                     input int unsigned bi, input bit ci, input bit creg);
        res_t   r;
        longint mask, half, sa, sb, s, ss, c;
        mask = (longint'(1) << W) - 1;
        half = longint'(1) << (W - 1);
        sa   = (ai >= half) ? longint'(ai) - (mask + 1) : longint'(ai);
        sb   = (bi >= half) ? longint'(bi) - (mask + 1) : longint'(bi);
        r = '{y: 0, cout: 0, ovf: 0, neg: 0, zero: 0, err: 0};
        case (o)
            0, 9: begin
                c      = (o == 0) ? longint'(ci) : longint'(creg);
                s      = longint'(ai) + longint'(bi) + c;
                ss     = sa + sb + c;
                r.y    = int'(s & mask);
                r.cout = s > mask;
                r.ovf  = (ss >= half) || (ss < -half);
            end
            1: begin
                s      = longint'(ai) - longint'(bi);
                ss     = sa - sb;
                r.y    = int'(s & mask);
                r.cout = ai >= bi;
                r.ovf  = (ss >= half) || (ss < -half);
            end
            2: r.y = ai & bi;
            3: r.y = ai | bi;
            4: r.y = ai ^ bi;
            5: r.y = int'(~longint'(ai) & mask);
            6: if (bi > 0 && bi < W) begin
                   r.y    = int'((longint'(ai) << bi) & mask);
                   r.cout = ((ai >> (W - bi)) & 1) != 0;
               end else if (bi == 0) r.y = ai;
            7: if (bi > 0 && bi < W) begin
                   r.y    = ai >> bi;
                   r.cout = ((ai >> (bi - 1)) & 1) != 0;
               end else if (bi == 0) r.y = ai;
            8: if (bi >= W) begin
                   r.y    = (ai >= half) ? int'(mask) : 0;
                   r.cout = ai >= half;
               end else if (bi == 0) r.y = ai;
               else begin
                   r.y    = int'((sa >>> bi) & mask);
                   r.cout = ((ai >> (bi - 1)) & 1) != 0;
               end
            10: begin
                s      = longint'(ai) * longint'(bi);
                r.y    = int'(s & mask);
                r.cout = (s >> W) != 0;
            end
            default: r.err = 1;
        endcase
        r.neg  = ((r.y >> (W - 1)) & 1) != 0;
        r.zero = (r.y == 0);
        return r;
    endfunction

    // Handshake model: one result slot, MUL blocks the input for W cycles.
    bit   started = 0;
    bit   m_vld = 0;
    bit   m_c = 0;
    int   busy = 0;
    res_t m_res, m_pend, nres;
    bit   m_ready, load;

    always @(negedge clk) begin
        m_ready = !rst && busy == 0 && (!m_vld || out_ready);
        if (started) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(m_vld));
            if (m_vld) begin
                check("y", 32'(y), m_res.y);
                check("cout", 32'(cout), 32'(m_res.cout));
                check("overflow", 32'(overflow), 32'(m_res.ovf));
                check("negative", 32'(negative), 32'(m_res.neg));
                check("zero", 32'(zero), 32'(m_res.zero));
                check("err", 32'(err), 32'(m_res.err));
            end
        end
        if (rst) begin
            started = 1;
            m_vld   = 0;
            m_c     = 0;
            busy    = 0;
        end else if (started) begin
            load = 0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    load = 1;
                    nres = m_pend;
                end
            end else if (in_valid && m_ready) begin
                if (op == T_MUL) begin
                    busy   = W;
                    m_pend = ref_alu(op, a, b, cin, m_c);
                end else begin
                    load = 1;
                    nres = ref_alu(op, a, b, cin, m_c);
                end
            end
            if (load) begin
                m_vld = 1;
                m_res = nres;
                if (!nres.err) m_c = nres.cout;
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c);
        int k = 0;
        @(posedge clk); #1;
        op = o; a = aa; b = bb; cin = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Expects out_valid exactly at the lat-th negedge after acceptance, in_ready low before.
    task automatic expect_res(input string tag, input int lat, input logic [W-1:0] ey,
                              input bit ec, input bit eo, input bit en, input bit ez, input bit ee);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({tag, "_busy_vld"}, 32'(out_valid), 32'd0);
            check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(y), 32'(ey));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_neg"}, 32'(negative), 32'(en));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_flags", 32'({cout, overflow, negative, zero, err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        issue(T_ARS, 4'b1001, 4'b0001, 1'b0);
        expect_res("ars1", 1, 4'b1100, 1, 0, 1, 0, 0);
        issue(T_ADD, 4'b1111, 4'b0001, 1'b0);
        expect_res("add_c", 1, 4'b0000, 1, 0, 0, 1, 0);
        issue(T_ADC, 4'b0000, 4'b0000, 1'b0);
        expect_res("adc", 1, 4'b0001, 0, 0, 0, 0, 0);
        issue(T_ADD, 4'b0111, 4'b0001, 1'b0);
        expect_res("add_ovf", 1, 4'b1000, 0, 1, 1, 0, 0);
        issue(T_SUB, 4'b0011, 4'b0101, 1'b1);
        expect_res("sub", 1, 4'b1110, 0, 0, 1, 0, 0);
        issue(T_MUL, 4'b0011, 4'b0101, 1'b0);
        expect_res("mul15", 5, 4'b1111, 0, 0, 1, 0, 0);
        issue(T_MUL, 4'b0100, 4'b0100, 1'b0);
        expect_res("mul16", 5, 4'b0000, 1, 0, 0, 1, 0);
        issue(T_LLS, 4'b1111, 4'b0100, 1'b0);
        expect_res("lls4", 1, 4'b0000, 0, 0, 0, 1, 0);
        issue(T_ARS, 4'b1000, 4'b0111, 1'b0);
        expect_res("ars7", 1, 4'b1111, 1, 0, 1, 0, 0);
        issue(4'b1111, 4'b0101, 4'b0011, 1'b0);
        expect_res("illegal", 1, 4'b0000, 0, 0, 0, 1, 1);
        issue(T_ADC, 4'b0000, 4'b0000, 1'b0);
        expect_res("adc_keepc", 1, 4'b0001, 0, 0, 0, 0, 0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(T_XOR, 4'b1100, 4'b1010, 1'b0);
        op = T_ADD; a = 4'd1; b = 4'd1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_y", 32'(y), 32'b0110);
            check("stall_rdy", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release_vld", 32'(out_valid), 32'd1);
        check("release_y", 32'(y), 32'b0110);
        @(negedge clk);
        check("drained_vld", 32'(out_valid), 32'd0);

        issue(T_MUL, 4'b0011, 4'b0101, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_none", 32'(out_valid), 32'd0);
        end

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = ($urandom_range(0, 4) == 0) ? T_MUL : 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
